// File: rtl/ppi_bus_master_if.sv
// ppi_bus_master_if
//  Groups the host request/response handshake and the 8255A bus pins of the
//  PPI bus master into one bundle.
//  Host side : req_valid, req_ready, req_wr, req_addr[1:0], req_wdata[7:0],
//              rsp_valid, rsp_rdata[7:0]
//  PPI side  : nCS, nRD, nWR, A[1:0], Dout[7:0], DoutEn, Din[7:0]
//  modport master : the bus master itself (drives strobes, consumes requests)
//  modport slave  : the environment (host plus PPI) facing the master
interface ppi_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       nCS;
    logic       nRD;
    logic       nWR;
    logic [1:0] A;
    logic [7:0] Dout;
    logic       DoutEn;
    logic [7:0] Din;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, Din,
        output req_ready, rsp_valid, rsp_rdata,
        output nCS, nRD, nWR, A, Dout, DoutEn
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, Din,
        input  req_ready, rsp_valid, rsp_rdata,
        input  nCS, nRD, nWR, A, Dout, DoutEn
    );
endinterface

// File: rtl/ppi_bus_master.sv
// ppi_bus_master
//  CPU-side bus initiator for the 8255A PPI. Each accepted host request becomes
//  one nCS/nRD/nWR bus cycle with programmable setup, strobe, hold and recovery
//  times; read data is returned on rsp_rdata with a one-cycle rsp_valid pulse.
//  Ports:
//    clk     : system clock, rising edge
//    nReset  : asynchronous active-low reset, abandons any cycle in flight
//    bus     : ppi_bus_master_if.master (host handshake + PPI pins)
//  Parameters (cycles, 1..15): T_SETUP, T_STROBE, T_HOLD, T_RECOVER
//  Every output is driven straight from a flop.
module ppi_bus_master #(
    parameter int unsigned T_SETUP   = 1,
    parameter int unsigned T_STROBE  = 3,
    parameter int unsigned T_HOLD    = 1,
    parameter int unsigned T_RECOVER = 2
) (
    input  logic            clk,
    input  logic            nReset,
    ppi_bus_master_if.master bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    // Counter reload values: a state lasting T cycles is left when the counter reads 0.
    localparam logic [3:0] LOAD_SETUP   = 4'(T_SETUP   - 32'd1);
    localparam logic [3:0] LOAD_STROBE  = 4'(T_STROBE  - 32'd1);
    localparam logic [3:0] LOAD_HOLD    = 4'(T_HOLD    - 32'd1);
    localparam logic [3:0] LOAD_RECOVER = 4'(T_RECOVER - 32'd1);

    logic [2:0] state_r,  state_s;
    logic [3:0] cnt_r,    cnt_s;
    logic       wr_r,     wr_s;
    logic       ncs_r,    ncs_s;
    logic       nrd_r,    nrd_s;
    logic       nwr_r,    nwr_s;
    logic [1:0] a_r,      a_s;
    logic [7:0] dout_r,   dout_s;
    logic       douten_r, douten_s;
    logic       ready_r,  ready_s;
    logic       rspv_r,   rspv_s;
    logic [7:0] rdata_r,  rdata_s;
    logic       done_s;

    // Next-state and next-output computation for the bus cycle sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        wr_s     = wr_r;
        ncs_s    = ncs_r;
        nrd_s    = nrd_r;
        nwr_s    = nwr_r;
        a_s      = a_r;
        dout_s   = dout_r;
        douten_s = douten_r;
        ready_s  = ready_r;
        rspv_s   = 1'b0;
        rdata_s  = rdata_r;
        done_s   = (cnt_r == 4'd0);

        case (state_r)
            IDLE: begin
                // ready_r (not a fresh 1) gates the handshake so that nothing is
                // accepted on the first edge after reset release.
                if (bus.req_valid && ready_r) begin
                    state_s = SETUP;
                    cnt_s   = LOAD_SETUP;
                    wr_s    = bus.req_wr;
                    a_s     = bus.req_addr;
                    ncs_s   = 1'b0;
                    ready_s = 1'b0;
                    if (bus.req_wr) begin
                        dout_s   = bus.req_wdata;
                        douten_s = 1'b1;
                    end else begin
                        douten_s = 1'b0;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            SETUP: begin
                if (done_s) begin
                    state_s = STROBE;
                    cnt_s   = LOAD_STROBE;
                    // Exactly one strobe goes low, chosen by the latched direction.
                    nrd_s   = wr_r;
                    nwr_s   = ~wr_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            STROBE: begin
                if (done_s) begin
                    state_s = HOLD;
                    cnt_s   = LOAD_HOLD;
                    nrd_s   = 1'b1;
                    nwr_s   = 1'b1;
                    rspv_s  = 1'b1;
                    if (!wr_r) begin
                        rdata_s = bus.Din;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            HOLD: begin
                if (done_s) begin
                    state_s  = RECOVER;
                    cnt_s    = LOAD_RECOVER;
                    ncs_s    = 1'b1;
                    douten_s = 1'b0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RECOVER: begin
                if (done_s) begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                    ready_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                // Unreachable encoding: park the bus in its idle, released state.
                state_s  = IDLE;
                cnt_s    = 4'd0;
                ncs_s    = 1'b1;
                nrd_s    = 1'b1;
                nwr_s    = 1'b1;
                douten_s = 1'b0;
                ready_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            wr_r     <= 1'b0;
            ncs_r    <= 1'b1;
            nrd_r    <= 1'b1;
            nwr_r    <= 1'b1;
            a_r      <= 2'b00;
            dout_r   <= 8'h00;
            douten_r <= 1'b0;
            ready_r  <= 1'b0;
            rspv_r   <= 1'b0;
            rdata_r  <= 8'h00;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            wr_r     <= wr_s;
            ncs_r    <= ncs_s;
            nrd_r    <= nrd_s;
            nwr_r    <= nwr_s;
            a_r      <= a_s;
            dout_r   <= dout_s;
            douten_r <= douten_s;
            ready_r  <= ready_s;
            rspv_r   <= rspv_s;
            rdata_r  <= rdata_s;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rspv_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.nCS       = ncs_r;
    assign bus.nRD       = nrd_r;
    assign bus.nWR       = nwr_r;
    assign bus.A         = a_r;
    assign bus.Dout      = dout_r;
    assign bus.DoutEn    = douten_r;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master
//  Directed bench for ppi_bus_master. dut0 uses the default timing, dut1 uses
//  T_SETUP=2, T_STROBE=1, T_HOLD=2, T_RECOVER=1. Cycle k is the clock period
//  following edge k-1, where edge 0 is the handshake edge; outputs are sampled
//  on the falling edge in the middle of each cycle.
module tb_ppi_bus_master;

    logic clk = 1'b0;
    logic nReset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ppi_bus_master_if bus0();
    ppi_bus_master_if bus1();

    ppi_bus_master dut0 (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus0.master)
    );

    ppi_bus_master #(
        .T_SETUP   (2),
        .T_STROBE  (1),
        .T_HOLD    (2),
        .T_RECOVER (1)
    ) dut1 (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus1.master)
    );

    // sampled view of the selected DUT
    logic       s_ncs, s_nrd, s_nwr, s_douten, s_ready, s_rspv;
    logic [1:0] s_a;
    logic [7:0] s_dout, s_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap(input int d);
        if (d == 0) begin
            s_ncs = bus0.nCS; s_nrd = bus0.nRD; s_nwr = bus0.nWR; s_douten = bus0.DoutEn;
            s_ready = bus0.req_ready; s_rspv = bus0.rsp_valid; s_a = bus0.A;
            s_dout = bus0.Dout; s_rdata = bus0.rsp_rdata;
        end else begin
            s_ncs = bus1.nCS; s_nrd = bus1.nRD; s_nwr = bus1.nWR; s_douten = bus1.DoutEn;
            s_ready = bus1.req_ready; s_rspv = bus1.rsp_valid; s_a = bus1.A;
            s_dout = bus1.Dout; s_rdata = bus1.rsp_rdata;
        end
    endtask

    task automatic drive(input int d, input logic v, input logic wr, input logic [1:0] ad, input logic [7:0] wd);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_wr = wr; bus0.req_addr = ad; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = v; bus1.req_wr = wr; bus1.req_addr = ad; bus1.req_wdata = wd;
        end
    endtask

    task automatic set_din(input int d, input logic [7:0] v);
        if (d == 0) bus0.Din = v;
        else        bus1.Din = v;
    endtask

    // Wait (bounded) at falling edges until the selected DUT is ready.
    task automatic wait_ready(input int d, input string tag);
        snap(d);
        for (int i = 0; i < 20 && !s_ready; i++) begin
            @(negedge clk);
            snap(d);
        end
        if (!s_ready) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // One request; windows are hand-computed: nCS low 1..cs_last, strobe low
    // st_first..st_last, rsp_valid at st_last+1, req_ready back at rdy_cyc.
    task automatic run_txn(input string tag, input int d, input logic wr, input logic [1:0] ad,
                           input logic [7:0] wd, input int cs_last, input int st_first,
                           input int st_last, input int rdy_cyc, input logic [7:0] din_st,
                           input logic [7:0] exp_rdata);
        logic strobe_lo;
        wait_ready(d, tag);
        drive(d, 1'b1, wr, ad, wd);
        set_din(d, din_st);
        @(posedge clk);
        for (int k = 1; k <= rdy_cyc; k++) begin
            @(negedge clk);
            if (k == 1) drive(d, 1'b0, 1'b0, 2'b00, 8'h00);
            set_din(d, (k <= st_last) ? din_st : 8'hFF);
            snap(d);
            strobe_lo = (k >= st_first) && (k <= st_last);
            check_val($sformatf("%s_nCS_c%0d", tag, k), 32'(s_ncs), 32'(!(k <= cs_last)));
            check_val($sformatf("%s_nWR_c%0d", tag, k), 32'(s_nwr), 32'(!(wr && strobe_lo)));
            check_val($sformatf("%s_nRD_c%0d", tag, k), 32'(s_nrd), 32'(!(!wr && strobe_lo)));
            check_val($sformatf("%s_DoutEn_c%0d", tag, k), 32'(s_douten), 32'(wr && (k <= cs_last)));
            check_val($sformatf("%s_A_c%0d", tag, k), 32'(s_a), 32'(ad));
            if (wr) check_val($sformatf("%s_Dout_c%0d", tag, k), 32'(s_dout), 32'(wd));
            check_val($sformatf("%s_rspv_c%0d", tag, k), 32'(s_rspv), 32'(k == st_last + 1));
            check_val($sformatf("%s_ready_c%0d", tag, k), 32'(s_ready), 32'(k == rdy_cyc));
        end
        check_val({tag, "_rdata"}, 32'(s_rdata), 32'(exp_rdata));
    endtask

    initial begin
        nReset = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 8'h00);
        drive(1, 1'b0, 1'b0, 2'b00, 8'h00);
        set_din(0, 8'h00);
        set_din(1, 8'h00);

        // 1: reset values, req_ready rises on the first edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        snap(0);
        check_val("rst_nCS", 32'(s_ncs), 32'd1);
        check_val("rst_nRD", 32'(s_nrd), 32'd1);
        check_val("rst_nWR", 32'(s_nwr), 32'd1);
        check_val("rst_DoutEn", 32'(s_douten), 32'd0);
        check_val("rst_ready", 32'(s_ready), 32'd0);
        check_val("rst_rdata", 32'(s_rdata), 32'd0);
        check_val("rst_A", 32'(s_a), 32'd0);
        nReset = 1'b1;
        #1;
        snap(0);
        check_val("rel_ready_before_edge", 32'(s_ready), 32'd0);
        @(negedge clk);
        snap(0);
        check_val("rel_ready_after_edge", 32'(s_ready), 32'd1);

        // 2: control word write
        run_txn("wr80", 0, 1'b1, 2'b11, 8'h80, 5, 2, 4, 8, 8'h00, 8'h00);

        // 3: read PA, Din changes after STROBE must not matter
        run_txn("rdPA", 0, 1'b0, 2'b00, 8'h00, 5, 2, 4, 8, 8'h5A, 8'h5A);

        // 4: back-to-back writes with req_valid held high
        wait_ready(0, "b2b");
        drive(0, 1'b1, 1'b1, 2'b11, 8'h0F);
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 1'b1, 1'b1, 2'b11, 8'h0E);
            if (k == 9) drive(0, 1'b0, 1'b0, 2'b00, 8'h00);
            snap(0);
            check_val($sformatf("b2b_nCS_c%0d", k), 32'(s_ncs),
                      32'(!((k >= 1 && k <= 5) || (k >= 9 && k <= 13))));
            check_val($sformatf("b2b_nWR_c%0d", k), 32'(s_nwr),
                      32'(!((k >= 2 && k <= 4) || (k >= 10 && k <= 12))));
            check_val($sformatf("b2b_ready_c%0d", k), 32'(s_ready), 32'(k == 8 || k == 16));
            check_val($sformatf("b2b_Dout_c%0d", k), 32'(s_dout), (k <= 8) ? 32'h0F : 32'h0E);
        end
        check_val("b2b_rdata_kept", 32'(s_rdata), 32'h5A);

        // 5: reset in cycle 3 of a write abandons it
        wait_ready(0, "rstmid");
        drive(0, 1'b1, 1'b1, 2'b01, 8'h33);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        snap(0);
        check_val("rstmid_nWR_before", 32'(s_nwr), 32'd0);
        nReset = 1'b0;
        #1;
        snap(0);
        check_val("rstmid_nWR", 32'(s_nwr), 32'd1);
        check_val("rstmid_nCS", 32'(s_ncs), 32'd1);
        check_val("rstmid_DoutEn", 32'(s_douten), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            snap(0);
            check_val($sformatf("rstmid_rspv_%0d", k), 32'(s_rspv), 32'd0);
        end
        nReset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            snap(0);
            check_val($sformatf("rstmid_rel_rspv_%0d", k), 32'(s_rspv), 32'd0);
        end
        run_txn("rdPB", 0, 1'b0, 2'b01, 8'h00, 5, 2, 4, 8, 8'h3C, 8'h3C);

        // 6: alternative timing on dut1
        run_txn("t6wr", 1, 1'b1, 2'b10, 8'hA5, 5, 3, 3, 7, 8'h00, 8'h00);
        run_txn("t6rd", 1, 1'b0, 2'b01, 8'h00, 5, 3, 3, 7, 8'hC3, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "time limit reached");
    end

endmodule
